// File: rtl/rfarb_pkg.sv
// rfarb_pkg: shared constants, the write-queue entry type and a small decode helper for the
// register-file write arbiter.
package rfarb_pkg;

    localparam int          RFARB_DEPTH    = 4;
    localparam logic [4:0]  RFARB_ZERO_REG = 5'd31;
    localparam int          RFARB_PTR_W    = $clog2(RFARB_DEPTH);
    localparam int          RFARB_CNT_W    = $clog2(RFARB_DEPTH + 1);

    // One queued register-file write.
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } rfarb_entry_t;

    // One-hot decode of a register index into a 32-bit mask.
    function automatic logic [31:0] rfarb_onehot(input logic [4:0] idx);
        logic [31:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rfarb_fifo.sv
// rfarb_fifo: in-order write queue of {reg, data} entries with a per-register pending mask
// covering every entry currently held.
module rfarb_fifo
    import rfarb_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  rfarb_entry_t           i_entry,
    input  logic                   i_pop,
    output logic [RFARB_CNT_W-1:0] o_count,
    output rfarb_entry_t           o_head,
    output logic [31:0]            o_pending
);

    rfarb_entry_t            r_mem [RFARB_DEPTH];
    logic [RFARB_PTR_W-1:0]  r_wr_ptr;
    logic [RFARB_PTR_W-1:0]  r_rd_ptr;
    logic [RFARB_CNT_W-1:0]  r_count;
    logic                    w_pop;
    logic [RFARB_PTR_W-1:0]  w_off;

    // A pop on an empty queue is ignored so the count can never wrap.
    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < RFARB_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + RFARB_CNT_W'(i_push) - RFARB_CNT_W'(w_pop);
        end
    end

    // Pending mask: OR of the decoded targets of all occupied slots, so duplicates keep the
    // bit set until the last one leaves.
    always_comb begin
        o_pending = '0;
        w_off     = '0;
        for (int i = 0; i < RFARB_DEPTH; i++) begin
            // Distance of slot i from the head; slot is occupied when that is below count.
            w_off = RFARB_PTR_W'(i) - r_rd_ptr;
            if ({1'b0, w_off} < r_count) begin
                o_pending = o_pending | rfarb_onehot(r_mem[i].rd);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates execute and memory writeback write requests into a
// 4-entry in-order queue that drains to the register file write port.
// Build option: define RFARB_FIXED_PRIO_EN for strict Mem-over-Ex priority (no RR pointer).
module regfile_write_arbiter
    import rfarb_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ExValid,
    input  logic        MemValid,
    output logic        ExReady,
    output logic        MemReady,
    input  logic [4:0]  ExReg,
    input  logic [4:0]  MemReg,
    input  logic [63:0] ExData,
    input  logic [63:0] MemData,
    input  logic        Hold,
    output logic        WE,
    output logic [4:0]  WReg,
    output logic [63:0] Data,
    output logic [31:0] Pending
);

    logic [RFARB_CNT_W-1:0] w_count;
    rfarb_entry_t           w_head;
    rfarb_entry_t           w_push_entry;
    logic                   w_full;
    logic                   w_ex_grant;
    logic                   w_mem_grant;
    logic                   w_push;
    logic                   w_pop;

    // No pass-through when full: a pop this cycle does not free a slot for a push.
    assign w_full = (w_count == RFARB_CNT_W'(RFARB_DEPTH));

`ifdef RFARB_FIXED_PRIO_EN
    // Ready: Mem always wins; Ex only when Mem is idle.
    always_comb begin
        MemReady = Rst_n && !w_full;
        ExReady  = Rst_n && !w_full && !MemValid;
    end
`else
    localparam logic PTR_EX  = 1'b0;
    localparam logic PTR_MEM = 1'b1;

    logic r_ptr;

    // Ready: a port may proceed when the other is idle or the pointer favours it.
    always_comb begin
        MemReady = Rst_n && !w_full && ((r_ptr == PTR_MEM) || !ExValid);
        ExReady  = Rst_n && !w_full && ((r_ptr == PTR_EX) || !MemValid);
    end

    // Round-robin pointer: hand priority to the other port after every grant.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_ptr <= PTR_MEM;
        end else if (w_mem_grant) begin
            r_ptr <= PTR_EX;
        end else if (w_ex_grant) begin
            r_ptr <= PTR_MEM;
        end
    end
`endif

    // Grant selection and queue push; writes to the zero register are accepted but dropped.
    always_comb begin
        w_mem_grant  = MemValid && MemReady;
        w_ex_grant   = ExValid && ExReady;
        w_push_entry = '0;
        if (w_mem_grant) begin
            w_push_entry.rd   = MemReg;
            w_push_entry.data = MemData;
        end else if (w_ex_grant) begin
            w_push_entry.rd   = ExReg;
            w_push_entry.data = ExData;
        end
        w_push = (w_mem_grant || w_ex_grant) && (w_push_entry.rd != RFARB_ZERO_REG);
    end

    // Write port: present the head whenever the queue is non-empty and the port is free.
    always_comb begin
        WE    = (w_count != '0) && !Hold;
        w_pop = WE;
        WReg  = '0;
        Data  = '0;
        if (w_count != '0) begin
            WReg = w_head.rd;
            Data = w_head.data;
        end
    end

    rfarb_fifo u_fifo (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_push    (w_push),
        .i_entry   (w_push_entry),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_pending (Pending)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        ExValid, MemValid;
    logic        ExReady, MemReady;
    logic [4:0]  ExReg, MemReg;
    logic [63:0] ExData, MemData;
    logic        Hold;
    logic        WE;
    logic [4:0]  WReg;
    logic [63:0] Data;
    logic [31:0] Pending;

    int n_errors = 0;
    int n_checks = 0;

    // Writes as seen by the register file (sampled on negedge).
    logic [68:0] wr_q[$];

    regfile_write_arbiter dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ExValid  (ExValid),
        .MemValid (MemValid),
        .ExReady  (ExReady),
        .MemReady (MemReady),
        .ExReg    (ExReg),
        .MemReg   (MemReg),
        .ExData   (ExData),
        .MemData  (MemData),
        .Hold     (Hold),
        .WE       (WE),
        .WReg     (WReg),
        .Data     (Data),
        .Pending  (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (WE) wr_q.push_back({WReg, Data});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [4:0] rd,
                          input logic [63:0] dat);
        logic [68:0] e;
        e = (idx < wr_q.size()) ? wr_q[idx] : '1;
        chk({tag, "_reg"}, 64'(e[68:64]), 64'(rd));
        chk({tag, "_data"}, e[63:0], dat);
    endtask

    // Advance one clock edge and settle past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [4:0] exp_order [4];
    logic [4:0] mem_regs [2];
    logic [4:0] ex_regs [2];

    initial begin
        int mi;
        int ei;
        logic macc;
        logic eacc;

        Rst_n    = 1'b0;
        ExValid  = 1'b1;
        MemValid = 1'b1;
        ExReg    = 5'd5;
        MemReg   = 5'd6;
        ExData   = 64'h1;
        MemData  = 64'h2;
        Hold     = 1'b0;
        #2;
        // Reset state
        chk("rst_we", 64'(WE), 64'd0);
        chk("rst_wreg", 64'(WReg), 64'd0);
        chk("rst_data", Data, 64'd0);
        chk("rst_pending", 64'(Pending), 64'd0);
        chk("rst_exready", 64'(ExReady), 64'd0);
        chk("rst_memready", 64'(MemReady), 64'd0);
        tick();
        ExValid  = 1'b0;
        MemValid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single Ex write, first edge after reset release
        ExValid = 1'b1;
        ExReg   = 5'd5;
        ExData  = 64'hAA;
        #1;
        chk("single_exready", 64'(ExReady), 64'd1);
        chk("single_we_pre", 64'(WE), 64'd0);
        tick();
        ExValid = 1'b0;
        #1;
        chk("single_we", 64'(WE), 64'd1);
        chk("single_wreg", 64'(WReg), 64'd5);
        chk("single_data", Data, 64'hAA);
        chk("single_pending", 64'(Pending), 64'h20);
        tick();
        chk("single_we_after", 64'(WE), 64'd0);
        chk("single_pending_after", 64'(Pending), 64'd0);

        // Both ports valid: arbitration order
        wr_q.delete();
        mem_regs = '{5'd1, 5'd2};
        ex_regs  = '{5'd3, 5'd4};
`ifdef RFARB_FIXED_PRIO_EN
        exp_order = '{5'd1, 5'd2, 5'd3, 5'd4};
`else
        exp_order = '{5'd1, 5'd3, 5'd2, 5'd4};
`endif
        mi = 0;
        ei = 0;
        MemValid = 1'b1;
        ExValid  = 1'b1;
        MemReg   = mem_regs[0];
        ExReg    = ex_regs[0];
        MemData  = 64'(mem_regs[0]) * 64'h11;
        ExData   = 64'(ex_regs[0]) * 64'h11;
        #1;
        chk("both_memready", 64'(MemReady), 64'd1);
        chk("both_exready", 64'(ExReady), 64'd0);
        for (int c = 0; c < 6; c++) begin
            macc = MemValid && MemReady;
            eacc = ExValid && ExReady;
            tick();
            if (macc) mi++;
            if (eacc) ei++;
            MemValid = (mi < 2);
            ExValid  = (ei < 2);
            MemReg   = (mi < 2) ? mem_regs[mi] : 5'd0;
            ExReg    = (ei < 2) ? ex_regs[ei] : 5'd0;
            MemData  = 64'(MemReg) * 64'h11;
            ExData   = 64'(ExReg) * 64'h11;
            #1;
        end
        MemValid = 1'b0;
        ExValid  = 1'b0;
        tick();
        tick();
        chk("both_count", 64'(wr_q.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk_wr("both_order", k, exp_order[k], 64'(exp_order[k]) * 64'h11);
        end

        // Zero register write is accepted and dropped
        wr_q.delete();
        ExValid = 1'b1;
        ExReg   = 5'd31;
        ExData  = 64'hFF;
        #1;
        chk("zero_exready", 64'(ExReady), 64'd1);
        tick();
        ExValid = 1'b0;
        #1;
        chk("zero_we", 64'(WE), 64'd0);
        chk("zero_pending", 64'(Pending), 64'd0);
        tick();
        chk("zero_writes", 64'(wr_q.size()), 64'd0);

        // Hold with five requests: four fill the queue, fifth waits
        wr_q.delete();
        Hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ExValid = 1'b1;
            ExReg   = 5'(6 + k);
            ExData  = 64'h100 + 64'(6 + k);
            #1;
            chk("hold_exready", 64'(ExReady), 64'd1);
            tick();
        end
        ExReg  = 5'd10;
        ExData = 64'h10A;
        #1;
        chk("hold_full_exready", 64'(ExReady), 64'd0);
        chk("hold_we", 64'(WE), 64'd0);
        chk("hold_pending", 64'(Pending), 64'h3C0);
        tick();
        chk("hold_full_exready2", 64'(ExReady), 64'd0);
        Hold = 1'b0;
        #1;
        chk("release_we", 64'(WE), 64'd1);
        chk("release_wreg", 64'(WReg), 64'd6);
        chk("release_full_nopass", 64'(ExReady), 64'd0);
        tick();
        chk("release_exready", 64'(ExReady), 64'd1);
        chk("release_wreg2", 64'(WReg), 64'd7);
        tick();
        ExValid = 1'b0;
        #1;
        chk("release_wreg3", 64'(WReg), 64'd8);
        chk("release_pending", 64'(Pending), 64'h700);
        for (int k = 0; k < 5; k++) tick();
        chk("release_count", 64'(wr_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk_wr("release_order", k, 5'(6 + k), 64'h100 + 64'(6 + k));
        end

        // Duplicate targets keep the pending bit until the last pops
        Hold    = 1'b1;
        ExValid = 1'b1;
        ExReg   = 5'd7;
        ExData  = 64'h1;
        tick();
        ExData = 64'h2;
        tick();
        ExValid = 1'b0;
        #1;
        chk("dup_pending_held", 64'(Pending), 64'h80);
        Hold = 1'b0;
        #1;
        chk("dup_pending_first", 64'(Pending), 64'h80);
        chk("dup_data_first", Data, 64'h1);
        tick();
        chk("dup_pending_second", 64'(Pending), 64'h80);
        chk("dup_we_second", 64'(WE), 64'd1);
        chk("dup_data_second", Data, 64'h2);
        tick();
        chk("dup_pending_clear", 64'(Pending), 64'd0);
        chk("dup_we_clear", 64'(WE), 64'd0);

        // Reset mid-operation drops queued writes
        Hold    = 1'b1;
        ExValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ExReg  = 5'(1 + k);
            ExData = 64'h50 + 64'(k);
            tick();
        end
        ExValid = 1'b0;
        #1;
        chk("rstq_pending_pre", 64'(Pending), 64'hE);
        wr_q.delete();
        Rst_n = 1'b0;
        #1;
        chk("rstq_we", 64'(WE), 64'd0);
        chk("rstq_pending", 64'(Pending), 64'd0);
        chk("rstq_exready", 64'(ExReady), 64'd0);
        Hold = 1'b0;
        tick();
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("rstq_no_writes", 64'(wr_q.size()), 64'd0);
        chk("rstq_pending_after", 64'(Pending), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port Clk, input, 1: single clock; all state updates on posedge.
REQ-002 SHALL have port Rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have ports ExValid, MemValid, inputs, 1: write request from execute or memory writeback.
REQ-004 SHALL have ports ExReady, MemReady, outputs, 1: request accepted this cycle.
REQ-005 SHALL have ports ExReg, MemReg, inputs, 5: destination register index.
REQ-006 SHALL have ports ExData, MemData, inputs, 64: write data.
REQ-007 SHALL have port Hold, input, 1: register file write port unavailable this cycle.
REQ-008 SHALL have ports WE (1), WReg (5), Data (64), outputs: register file write port; register file samples on negedge Clk.
REQ-009 SHALL have port Pending, output, 32: bit r set while any queued write targets register r.

Function
REQ-010 SHALL hold accepted writes in a 4-entry in-order FIFO of {reg, data}.
REQ-011 SHALL accept a request on posedge when Valid && Ready; Ready SHALL depend on count < 4 and the grant only, never on Valid of the same port.
REQ-012 SHALL grant at most one port per cycle; if one port is valid, it wins; if both are valid, the round-robin pointer decides.
REQ-013 SHALL move the pointer to the other port after each grant; with no grant it SHALL be unchanged.
REQ-014 SHALL deassert both Ready when count == 4, even if a pop occurs that cycle (no pass-through when full).
REQ-015 SHALL accept a request with Reg == 31 via normal arbitration, then discard it: no FIFO slot, no WE, no Pending bit.
REQ-016 SHALL drive WE = (count > 0) && !Hold; WReg/Data = FIFO head when count > 0, else 0.
REQ-017 SHALL pop the head on posedge when WE was high.
REQ-018 SHALL give minimum latency of one cycle: a request accepted at edge N with the FIFO empty and Hold low drives WE during cycle N+1 and pops at edge N+1.
REQ-019 SHALL, on simultaneous push and pop, update count by push - pop and keep order intact.
REQ-020 SHALL compute Pending as the OR over valid FIFO entries; duplicate targets SHALL keep the bit set until the last one pops.
REQ-021 SHALL keep count and FIFO state unchanged while Hold is high, except for pushes.

Reset
REQ-022 SHALL, while Rst_n is low: count = 0, FIFO invalid, pointer to Mem, WE = 0, WReg = 0, Data = 0, Pending = 0, both Ready = 0.
REQ-023 SHALL drop queued writes when reset asserts mid-operation; none reach the register file.
REQ-024 SHALL allow the first acceptance on the first posedge after Rst_n deasserts.

Configuration
REQ-025 SHALL, with RFARB_FIXED_PRIO_EN defined, give Mem strict priority over Ex; the pointer SHALL be absent.
REQ-026 SHALL, without RFARB_FIXED_PRIO_EN, use round-robin per REQ-012/013.

Structure
REQ-027 SHALL place RFARB_DEPTH = 4, RFARB_ZERO_REG = 5'd31 and the {reg[4:0], data[63:0]} entry type in shared package rfarb_pkg.
REQ-028 SHALL implement the FIFO and Pending derivation in sub-module rfarb_fifo; arbitration stays in the top module.

Verification
REQ-029 SHALL cover: empty FIFO, ExValid, ExReg = 5, ExData = 0xAA at edge 0 -> WE = 1, WReg = 5, Data = 0xAA in cycle 1; Pending[5] = 1 during cycle 1 only.
REQ-030 SHALL cover: both valid for 4 cycles, Mem regs 1,2, Ex regs 3,4 -> order Mem1, Ex3, Mem2, Ex4 (with FIXED_PRIO: Mem1, Mem2 first).
REQ-031 SHALL cover: Hold = 1, 5 requests to regs 6..10 -> 4 accepted, Ready = 0 on the 5th; release Hold -> writes 6, 7, 8, 9 in order, then 10 accepted.
REQ-032 SHALL cover: Ex writes reg 31, data 0xFF -> ExReady = 1, WE stays 0, Pending = 0.
REQ-033 SHALL cover: two queued writes to reg 7 under Hold -> Pending[7] stays 1 until the second pops.
REQ-034 SHALL cover: Rst_n low with 3 entries queued -> WE = 0, Pending = 0 immediately, and no writes after release.
